// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, frame line levels
// and the default bit timing used by both the transmitter and the receiver.
package uart_pkg;

   // Serializer states: line idle, start bit, eight data bits, stop bit
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   localparam int   DATA_BITS            = 8;
   localparam logic START_LEVEL          = 1'b0;
   localparam logic STOP_LEVEL           = 1'b1;
   localparam logic IDLE_LEVEL           = 1'b1;
   localparam int   DEFAULT_CLKS_PER_BIT = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO buffering bytes for the UART transmitter.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   wrreq       - push write_data when not full (dropped when full)
//   write_data  - byte to store
//   rdreq       - pop the head when not empty
//   read_data   - head of the queue, valid whenever empty is low
//   full, empty - occupancy flags derived from the pointers
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wrreq,
   input  logic [DATA_BITS-1:0] write_data,
   input  logic                 rdreq,
   output logic [DATA_BITS-1:0] read_data,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 2 ** FIFO_AW;

   // One extra wrap bit on each pointer distinguishes full from empty
   logic [FIFO_AW:0]     wr_ptr;
   logic [FIFO_AW:0]     rd_ptr;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic                 push;
   logic                 pop;

   // Flags reflect occupancy at the start of the cycle, so a write that
   // coincides with a pop while full is still dropped
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign push  = wrreq && !full;
   assign pop   = rdreq && !empty;

   assign read_data = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= write_data;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from a FIFO-style write port and sends
// them on txd as 8N1 frames (start, 8 data bits LSB first, stop).
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   wrreq       - write strobe, one byte per cycle
//   write_data  - byte to transmit
//   full        - FIFO full, writes this cycle are dropped
//   txd         - registered serial line, idles high
//   busy        - frame on the line or bytes still queued
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_AW      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wrreq,
   input  logic [DATA_BITS-1:0] write_data,
   output logic                 full,
   output logic                 txd,
   output logic                 busy
);

   localparam int            CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int            IDX_W    = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   tx_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 txd_n;
   logic                 rdreq;
   logic [DATA_BITS-1:0] read_data;
   logic                 empty;

   uart_tx_fifo #(
      .FIFO_AW(FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wrreq     (wrreq),
      .write_data(write_data),
      .rdreq     (rdreq),
      .read_data (read_data),
      .full      (full),
      .empty     (empty)
   );

   assign busy = (state != ST_IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         txd   <= IDLE_LEVEL;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
         txd   <= txd_n;
      end
   end

   // The txd register is loaded with the level of the bit that starts at
   // this edge, so the line changes on the same edge as the state
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      shift_n = shift;
      txd_n   = txd;
      rdreq   = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            txd_n = IDLE_LEVEL;
            if (!empty) begin
               rdreq   = 1'b1;
               shift_n = read_data;
               state_n = ST_START;
               txd_n   = START_LEVEL;
            end
         end
         ST_START: begin
            if (cnt == CNT_MAX) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = ST_DATA;
               txd_n   = shift[0];
            end
         end
         ST_DATA: begin
            if (cnt == CNT_MAX) begin
               cnt_n   = '0;
               shift_n = shift >> 1;
               if (idx == LAST_IDX) begin
                  state_n = ST_STOP;
                  txd_n   = STOP_LEVEL;
               end else begin
                  idx_n = idx + 1'b1;
                  txd_n = shift[1];
               end
            end
         end
         ST_STOP: begin
            // A queued byte starts its frame right away, with no idle gap
            if (cnt == CNT_MAX) begin
               cnt_n = '0;
               if (!empty) begin
                  rdreq   = 1'b1;
                  shift_n = read_data;
                  state_n = ST_START;
                  txd_n   = START_LEVEL;
               end else begin
                  state_n = ST_IDLE;
                  txd_n   = IDLE_LEVEL;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            txd_n   = IDLE_LEVEL;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A queue-and-timestamp model predicts
// full, busy and the txd waveform each cycle; a separate monitor decodes
// frames off txd and compares them against a scoreboard of accepted bytes.
module tb_uart_tx;

   localparam int CPB   = 10;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wrreq = 1'b0;
   logic [7:0] write_data = 8'h00;
   logic       full;
   logic       txd;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: bytes waiting in the FIFO, the byte on the line and the
   // edge at which the line becomes free again
   logic [7:0] model_q[$];
   logic [7:0] exp_bytes[$];
   int         exp_starts[$];
   logic [7:0] cur_byte = 8'h00;
   int         next_free = 0;
   int         cyc = 0;
   bit         checking = 1'b0;
   bit         was_full;

   // Monitor state
   bit         mon_active = 1'b0;
   int         mon_start = 0;
   int         mon_rel;
   int         mon_bit;
   logic [7:0] mon_byte;

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_AW     (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wrreq     (wrreq),
      .write_data(write_data),
      .full      (full),
      .txd       (txd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic void check_output(string name, int actual, int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
      end
   endfunction

   // Expected line level from frame position: start bit, data LSB first, stop
   function automatic int exp_txd();
      int fs;
      int b;
      if (cyc >= next_free) return 1;
      fs = next_free - FRAME;
      b  = (cyc - fs) / CPB;
      if (b == 0) return 0;
      if (b == 9) return 1;
      return int'(cur_byte[b-1]);
   endfunction

   // Reference model, advanced at every rising edge
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         model_q.delete();
         exp_bytes.delete();
         exp_starts.delete();
         next_free = 0;
      end else begin
         was_full = (model_q.size() == DEPTH);
         if (model_q.size() > 0 && cyc >= next_free) begin
            cur_byte  = model_q.pop_front();
            next_free = cyc + FRAME;
            exp_starts.push_back(cyc);
         end
         if (wrreq && !was_full) begin
            model_q.push_back(write_data);
            exp_bytes.push_back(write_data);
         end
      end
   end

   // Cycle-by-cycle comparison of the flags and the line level
   always @(negedge clk) begin
      if (checking) begin
         check_output("full", int'(full), int'(model_q.size() == DEPTH));
         check_output("busy", int'(busy), int'((model_q.size() > 0) || (cyc < next_free)));
         check_output("txd", int'(txd), exp_txd());
      end
   end

   // Frame monitor: detect a start bit, sample each bit mid-way, then pop
   // the scoreboard and compare
   always @(negedge clk) begin
      if (reset || !checking) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (txd == 1'b0) begin
            mon_active = 1'b1;
            mon_start  = cyc;
            if (exp_starts.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL frame_start: got frame at cycle %0d expected none", cyc);
            end else begin
               check_output("frame_start", cyc, exp_starts.pop_front());
            end
         end
      end else begin
         mon_rel = cyc - mon_start;
         if (mon_rel % CPB == CPB / 2) begin
            mon_bit = mon_rel / CPB;
            if (mon_bit == 0) begin
               check_output("start_bit", int'(txd), 0);
            end else if (mon_bit <= 8) begin
               mon_byte[mon_bit-1] = txd;
            end else begin
               check_output("stop_bit", int'(txd), 1);
               if (exp_bytes.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("[TB] FAIL frame_data: got 0x%02h expected no frame", mon_byte);
               end else begin
                  check_output("frame_data", int'(mon_byte), int'(exp_bytes.pop_front()));
               end
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [7:0] b);
      wrreq      = 1'b1;
      write_data = b;
      @(posedge clk);
      #2;
      wrreq = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(posedge clk);
         #2;
         if (model_q.size() == 0 && cyc >= next_free && !mon_active) done = 1'b1;
      end
      check_output("drain_timeout", int'(done), 1);
      check_output("all_sent", exp_bytes.size(), 0);
      idle_cycles(3);
   endtask

   initial begin
      idle_cycles(3);
      reset    = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      check_output("reset_txd", int'(txd), 1);
      check_output("reset_full", int'(full), 0);
      check_output("reset_busy", int'(busy), 0);
      @(posedge clk);
      #2;

      $display("[TB] single byte 0xAA");
      apply_stimulus(8'hAA);
      wait_idle();

      $display("[TB] back-to-back 0x55 0x0F");
      apply_stimulus(8'h55);
      apply_stimulus(8'h0F);
      wait_idle();

      $display("[TB] fill past full with 0x00..0x11");
      for (int i = 0; i < 18; i++) apply_stimulus(8'(i));
      @(negedge clk);
      check_output("full_after_burst", int'(full), 1);
      wait_idle();

      $display("[TB] extreme bytes 0x00 0xFF");
      apply_stimulus(8'h00);
      apply_stimulus(8'hFF);
      wait_idle();

      $display("[TB] random bursts");
      for (int r = 0; r < 8; r++) begin
         int len;
         len = $urandom_range(1, 22);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) != 0) apply_stimulus(8'($urandom));
            else idle_cycles(1);
         end
         idle_cycles($urandom_range(0, 150));
      end
      wait_idle();

      $display("[TB] reset during data bit 3");
      for (int i = 0; i < 4; i++) apply_stimulus(8'(8'hC3 + i));
      idle_cycles(42);
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check_output("abort_txd", int'(txd), 1);
      check_output("abort_full", int'(full), 0);
      check_output("abort_busy", int'(busy), 0);
      idle_cycles(300);
      check_output("abort_quiet_busy", int'(busy), 0);

      $display("[TB] traffic after abort");
      apply_stimulus(8'h3C);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
